// File: rtl/pwr_btn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pwr_btn_pkg
//  Description : Shared definitions for the power-button controller: the
//                2-bit FSM state encoding (also exported on btn_state for
//                register readback) and the default millisecond timings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwr_btn_pkg;

    // Encoding is visible to firmware through btn_state; do not renumber.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESS   = 2'b01,
        LONG    = 2'b10,
        HOLDOFF = 2'b11
    } btn_state_t;

    localparam int DEF_SHORT_MIN_MS  = 50;
    localparam int DEF_LONG_PRESS_MS = 4000;
    localparam int DEF_HOLDOFF_MS    = 500;
    localparam int DEF_CNT_W         = 13;

endpackage
`default_nettype wire

// File: rtl/pwr_btn_ms_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_btn_ms_timer
//  Description : Saturating millisecond counter shared by the PRESS and
//                HOLDOFF states. Clear wins over the tick, so a tick that
//                lands in the same cycle as a clear is dropped.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock    in   system clock
//    reset    in   synchronous active-low reset
//    clr      in   clear counter to zero
//    tick     in   1 ms enable, increments the counter
//    cmp_val  in   threshold for the ge output
//    ge       out  counter >= cmp_val
//    sat      out  counter == SAT_VAL
// ============================================================================
module pwr_btn_ms_timer
    import pwr_btn_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int SAT_VAL = DEF_LONG_PRESS_MS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             ge,
    output logic             sat
);

    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(SAT_VAL);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != SAT_CNT)) begin
            count <= count + 1'b1;
        end
    end

    assign ge  = (count >= cmp_val);
    assign sat = (count == SAT_CNT);

endmodule
`default_nettype wire

// File: rtl/power_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : power_button_ctrl
//  Description : Classifies debounced front-panel button presses as glitch,
//                short or long and issues one-clock power-on, graceful
//                power-off or forced power-off requests to the sequencer.
//  Revision    : 1.0 - initial release
//
//  Build option
//    PWR_BTN_FORCE_OFF_EN  defined  : long press (LONG state, force_off)
//                          undefined: no long-press handling, force_off = 0,
//                                     every qualified release is a short press
//
//  Ports
//    clock        in   system clock (25 MHz)
//    reset        in   synchronous active-low reset
//    int_1ms_en   in   one-clock enable, once per ms
//    key_level    in   debounced button level, 0 = pressed
//    pwr_good     in   1 = system powered
//    pwr_on_req   out  pulse: short press while off
//    pwr_off_req  out  pulse: short press while on
//    force_off    out  pulse: long-press threshold reached
//    btn_state    out  current FSM state encoding
// ============================================================================
module power_button_ctrl
    import pwr_btn_pkg::*;
#(
    parameter int SHORT_MIN_MS  = DEF_SHORT_MIN_MS,
    parameter int LONG_PRESS_MS = DEF_LONG_PRESS_MS,
    parameter int HOLDOFF_MS    = DEF_HOLDOFF_MS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       int_1ms_en,
    input  logic       key_level,
    input  logic       pwr_good,
    output logic       pwr_on_req,
    output logic       pwr_off_req,
    output logic       force_off,
    output logic [1:0] btn_state
);

    localparam logic [CNT_W-1:0] SHORT_CNT   = CNT_W'(SHORT_MIN_MS);
    localparam logic [CNT_W-1:0] HOLDOFF_CNT = CNT_W'(HOLDOFF_MS);

    btn_state_t       state;
    btn_state_t       state_nx;
    logic             key_prev;
    logic             fall;
    logic             rise;
    logic             cnt_clr;
    logic             cnt_ge;
    logic [CNT_W-1:0] cmp_val;
    logic             on_nx;
    logic             off_nx;

`ifdef PWR_BTN_FORCE_OFF_EN
    logic             cnt_sat;
    logic             force_nx;
`else
    // Saturation flag only feeds long-press detection, absent in this build.
    logic             cnt_sat_unused;
`endif

    assign fall = key_prev & ~key_level;
    assign rise = ~key_prev & key_level;

    // One comparator serves both timed states; only HOLDOFF needs its own limit.
    assign cmp_val = (state == HOLDOFF) ? HOLDOFF_CNT : SHORT_CNT;

    // Counter restarts on every state change.
    assign cnt_clr = (state_nx != state);

    pwr_btn_ms_timer #(
        .CNT_W   (CNT_W),
        .SAT_VAL (LONG_PRESS_MS)
    ) u_ms_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr),
        .tick    (int_1ms_en),
        .cmp_val (cmp_val),
        .ge      (cnt_ge),
`ifdef PWR_BTN_FORCE_OFF_EN
        .sat     (cnt_sat)
`else
        .sat     (cnt_sat_unused)
`endif
    );

    always_comb begin
        state_nx = state;
        on_nx    = 1'b0;
        off_nx   = 1'b0;
`ifdef PWR_BTN_FORCE_OFF_EN
        force_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nx = PRESS;
                end
            end
            PRESS: begin
`ifdef PWR_BTN_FORCE_OFF_EN
                // Long threshold beats a release landing in the same cycle.
                if (cnt_sat) begin
                    force_nx = 1'b1;
                    state_nx = rise ? HOLDOFF : LONG;
                end else
`endif
                if (rise) begin
                    if (cnt_ge) begin
                        on_nx    = ~pwr_good;
                        off_nx   = pwr_good;
                        state_nx = HOLDOFF;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
`ifdef PWR_BTN_FORCE_OFF_EN
            LONG: begin
                if (rise) begin
                    state_nx = HOLDOFF;
                end
            end
`endif
            HOLDOFF: begin
                // A key still held at expiry keeps us here; IDLE needs a fresh fall.
                if (cnt_ge && key_level) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            key_prev    <= 1'b1;
            pwr_on_req  <= 1'b0;
            pwr_off_req <= 1'b0;
        end else begin
            state       <= state_nx;
            key_prev    <= key_level;
            pwr_on_req  <= on_nx;
            pwr_off_req <= off_nx;
        end
    end

`ifdef PWR_BTN_FORCE_OFF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            force_off <= 1'b0;
        end else begin
            force_off <= force_nx;
        end
    end
`else
    assign force_off = 1'b0;
`endif

    assign btn_state = state;

endmodule
`default_nettype wire

// File: tb/tb_power_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_button_ctrl
//  Description : Self-checking bench for power_button_ctrl with
//                SHORT_MIN_MS=5, LONG_PRESS_MS=100, HOLDOFF_MS=10 and a
//                1 ms tick every 4 clocks. Inputs change and outputs are
//                read on the falling clock edge; a monitor counts pulses
//                shortly after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_button_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       int_1ms_en;
    logic       key_level;
    logic       pwr_good;
    logic       pwr_on_req;
    logic       pwr_off_req;
    logic       force_off;
    logic [1:0] btn_state;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int on_cnt, off_cnt, force_cnt;
    int on_at, off_at, force_at;
    int multi = 0;
    int wide  = 0;
    bit p_on, p_off, p_f;
    int div = 0;

    power_button_ctrl #(
        .SHORT_MIN_MS  (5),
        .LONG_PRESS_MS (100),
        .HOLDOFF_MS    (10),
        .CNT_W         (13)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .int_1ms_en  (int_1ms_en),
        .key_level   (key_level),
        .pwr_good    (pwr_good),
        .pwr_on_req  (pwr_on_req),
        .pwr_off_req (pwr_off_req),
        .force_off   (force_off),
        .btn_state   (btn_state)
    );

    always #5 clock = ~clock;

    // 1 ms tick: one clock in four, changed mid-cycle so it is stable at both edges.
    initial begin
        int_1ms_en = 1'b0;
        forever begin
            @(posedge clock);
            #3;
            div        = (div + 1) % 4;
            int_1ms_en = (div == 0);
        end
    end

    // Pulse monitor.
    initial begin
        p_on = 0; p_off = 0; p_f = 0;
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            if (pwr_on_req)  begin on_cnt++;    on_at    = cyc; end
            if (pwr_off_req) begin off_cnt++;   off_at   = cyc; end
            if (force_off)   begin force_cnt++; force_at = cyc; end
            if ((int'(pwr_on_req) + int'(pwr_off_req) + int'(force_off)) > 1) multi++;
            if ((pwr_on_req && p_on) || (pwr_off_req && p_off) || (force_off && p_f)) wide++;
            p_on  = pwr_on_req;
            p_off = pwr_off_req;
            p_f   = force_off;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clr_cnt();
        on_cnt = 0; off_cnt = 0; force_cnt = 0;
        on_at = -1; off_at = -1; force_at = -1;
    endtask

    // Press for ms milliseconds; pwr_good starts inverted and takes its final
    // value halfway, so only the level at release should matter.
    task automatic press_release(input bit pg, input int ms, output int fall_cyc,
                                 output int rise_cyc, output int held, output int rel);
        pwr_good  = ~pg;
        key_level = 1'b0;
        fall_cyc  = cyc + 1;
        step(ms * 2);
        pwr_good  = pg;
        step(ms * 2);
        held      = int'(btn_state);
        key_level = 1'b1;
        rise_cyc  = cyc + 1;
        step(1);
        rel       = int'(btn_state);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (btn_state != 2'b00 && n < 200) begin
            step(1);
            n++;
        end
    endtask

    typedef struct {
        bit         pg;
        int         ms;
        int         e_on;
        int         e_off;
        int         e_force;
        logic [1:0] s_held;
        logic [1:0] s_rel;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int f, r, held, rel, n, ticks;
        bit tk;

        vecs[0] = '{1'b0, 20,  1, 0, 0, 2'b01, 2'b11};
        vecs[1] = '{1'b1, 20,  0, 1, 0, 2'b01, 2'b11};
        vecs[2] = '{1'b1, 3,   0, 0, 0, 2'b01, 2'b00};
        vecs[3] = '{1'b0, 8,   1, 0, 0, 2'b01, 2'b11};
`ifdef PWR_BTN_FORCE_OFF_EN
        vecs[4] = '{1'b1, 150, 0, 0, 1, 2'b10, 2'b11};
        vecs[5] = '{1'b0, 150, 0, 0, 1, 2'b10, 2'b11};
`else
        vecs[4] = '{1'b1, 150, 0, 1, 0, 2'b01, 2'b11};
        vecs[5] = '{1'b0, 150, 1, 0, 0, 2'b01, 2'b11};
`endif

        // Reset state
        reset = 1'b0; key_level = 1'b1; pwr_good = 1'b0;
        clr_cnt();
        step(3);
        chk("rst_state", int'(btn_state), 0);
        chk("rst_on", int'(pwr_on_req), 0);
        chk("rst_off", int'(pwr_off_req), 0);
        chk("rst_force", int'(force_off), 0);
        reset = 1'b1;
        step(4);

        // Table-driven presses
        foreach (vecs[i]) begin
            clr_cnt();
            press_release(vecs[i].pg, vecs[i].ms, f, r, held, rel);
            chk($sformatf("v%0d_held_state", i), held, int'(vecs[i].s_held));
            chk($sformatf("v%0d_rel_state", i), rel, int'(vecs[i].s_rel));
            wait_idle(n);
            if (vecs[i].s_rel == 2'b11)
                chk_rng($sformatf("v%0d_holdoff_len", i), n, 38, 41);
            else
                chk($sformatf("v%0d_idle_wait", i), n, 0);
            step(4);
            chk($sformatf("v%0d_on_cnt", i), on_cnt, vecs[i].e_on);
            chk($sformatf("v%0d_off_cnt", i), off_cnt, vecs[i].e_off);
            chk($sformatf("v%0d_force_cnt", i), force_cnt, vecs[i].e_force);
            if (vecs[i].e_on == 1)    chk($sformatf("v%0d_on_latency", i), on_at, r);
            if (vecs[i].e_off == 1)   chk($sformatf("v%0d_off_latency", i), off_at, r);
            if (vecs[i].e_force == 1) chk_rng($sformatf("v%0d_force_time", i), force_at, f + 398, f + 401);
        end

        // Press during holdoff is discarded, and a key still held keeps HOLDOFF
        clr_cnt();
        press_release(1'b1, 150, f, r, held, rel);
        chk("hold_seq_rel_state", rel, 3);
        clr_cnt();
        step(20);
        chk("hold_seq_mid", int'(btn_state), 3);
        key_level = 1'b0;
        step(80);
        chk("hold_seq_key_low", int'(btn_state), 3);
        key_level = 1'b1;
        step(1);
        chk("hold_seq_exit", int'(btn_state), 0);
        step(4);
        chk("hold_seq_no_pulse", on_cnt + off_cnt + force_cnt, 0);

`ifdef PWR_BTN_FORCE_OFF_EN
        // Release in the exact cycle the counter reaches the long threshold
        clr_cnt();
        pwr_good  = 1'b0;
        key_level = 1'b0;
        step(1);
        ticks = 0; n = 0;
        while (ticks < 100 && n < 1000) begin
            tk = int_1ms_en;
            step(1);
            n++;
            if (tk) ticks++;
        end
        chk("sat_cycle_state", int'(btn_state), 1);
        key_level = 1'b1;
        step(1);
        chk("sat_release_state", int'(btn_state), 3);
        step(2);
        chk("sat_force_cnt", force_cnt, 1);
        chk("sat_short_cnt", on_cnt + off_cnt, 0);
        wait_idle(n);
        step(4);
`endif

        // Normal short press after a full holdoff
        clr_cnt();
        press_release(1'b1, 20, f, r, held, rel);
        wait_idle(n);
        step(4);
        chk("after_hold_off_cnt", off_cnt, 1);
        chk("after_hold_other_cnt", on_cnt + force_cnt, 0);

        // Reset mid-press, key released while reset is held
        clr_cnt();
        pwr_good  = 1'b1;
        key_level = 1'b0;
        step(200);
        reset = 1'b0;
        step(2);
        key_level = 1'b1;
        step(3);
        chk("rstmid_state", int'(btn_state), 0);
        chk("rstmid_outputs", int'(pwr_on_req) + int'(pwr_off_req) + int'(force_off), 0);
        reset = 1'b1;
        step(20);
        chk("rstmid_after_state", int'(btn_state), 0);
        chk("rstmid_no_pulse", on_cnt + off_cnt + force_cnt, 0);

        // Global pulse properties
        chk("pulse_exclusive", multi, 0);
        chk("pulse_width", wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
